idma_axi_read_issue_tracker: RTL and testbench

- Sits directly downstream of the AXI read/write legalizer on the read side. Consumes each legalized read request: AR channel beat plus read-datapath descriptor.
- Issues the AR beat to the AXI manager port through a registered stage. Queues the datapath descriptor in order for the read datapath.
- Bounds the number of bursts in flight by counting R-last handshakes, and reports busy and error status to the backend.

---
 rtl/idma_axi_read_issue_tracker.sv | 153 +++++++++++++++
 tb/tb_idma_axi_read_issue_tracker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_axi_read_issue_tracker.sv
// Read-side issue stage for the iDMA backend: registers legalized AR beats toward AXI,
// queues matching datapath descriptors in order, and bounds bursts in flight by R-last.
module idma_axi_read_issue_tracker #(
    parameter int unsigned NumOutstanding = 4,
    parameter type         ar_chan_t      = logic,
    parameter type         r_dp_req_t     = logic,
    localparam int unsigned CntW          = $clog2(NumOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // All handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, payload is held while valid & !ready, ready may be comb.
    input  ar_chan_t        req_ar_i,
    input  r_dp_req_t       req_dp_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    output ar_chan_t        ar_o,
    output logic            ar_valid_o,
    input  logic            ar_ready_i,
    output r_dp_req_t       dp_o,
    output logic            dp_valid_o,
    input  logic            dp_ready_i,
    input  logic            r_valid_i,
    input  logic            r_ready_i,
    input  logic            r_last_i,
    input  logic [1:0]      r_resp_i,
    output logic            busy_o,
    output logic            err_o,
    output logic [CntW-1:0] outstanding_o
);

    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(NumOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);

    ar_chan_t        ar_q, ar_d;
    logic            ar_valid_q, ar_valid_d;
    r_dp_req_t       mem_q [NumOutstanding];
    r_dp_req_t       mem_d [NumOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] fill_q, fill_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic            err_q, err_d;

    logic fifo_full, fifo_empty;
    logic accept, pop, r_hs, complete;
    logic unused_resp;

    assign unused_resp = r_resp_i[0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fifo_full   = (fill_q == MaxCnt);
        fifo_empty  = (fill_q == '0);
        // Throttle on accepted (not issued) bursts so the descriptor FIFO can never overrun.
        req_ready_o = (!ar_valid_q | ar_ready_i) & !fifo_full & (outstanding_q < MaxCnt);
        accept      = req_valid_i & req_ready_o;
        pop         = !fifo_empty & dp_ready_i;
        r_hs        = r_valid_i & r_ready_i;
        complete    = r_hs & r_last_i & (outstanding_q != '0);
    end

    always_comb begin
        ar_d       = ar_q;
        ar_valid_d = ar_valid_q;
        if (accept) begin
            ar_d       = req_ar_i;
            ar_valid_d = 1'b1;
        end else if (ar_valid_q && ar_ready_i) begin
            ar_d       = '0;
            ar_valid_d = 1'b0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (accept) begin
            mem_d[wr_ptr_q] = req_dp_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, complete})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        // Any error response flags, not just the last beat of a burst.
        err_d = r_hs & r_resp_i[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_q          <= '0;
            ar_valid_q    <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            ar_q          <= ar_d;
            ar_valid_q    <= ar_valid_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        ar_o          = ar_q;
        ar_valid_o    = ar_valid_q;
        dp_valid_o    = !fifo_empty;
        dp_o          = fifo_empty ? '0 : mem_q[rd_ptr_q];
        busy_o        = ar_valid_q | (outstanding_q != '0);
        err_o         = err_q;
        outstanding_o = outstanding_q;
    end

    a_ar_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ar_valid_o && !ar_ready_i) |=> $stable(ar_o));

    a_no_spurious_completion : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_i && r_ready_i && r_last_i) |-> (outstanding_q != '0));

    a_no_pop_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> !fifo_empty);

    a_fill_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fill_q <= MaxCnt);

endmodule

// File: tb/tb_idma_axi_read_issue_tracker.sv
// Bench for idma_axi_read_issue_tracker: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_idma_axi_read_issue_tracker;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;
    typedef logic [15:0] dp_t;

    logic          clk_i;
    logic          rst_ni;
    ar_t           req_ar_i;
    dp_t           req_dp_i;
    logic          req_valid_i;
    logic          req_ready_o;
    ar_t           ar_o;
    logic          ar_valid_o;
    logic          ar_ready_i;
    dp_t           dp_o;
    logic          dp_valid_o;
    logic          dp_ready_i;
    logic          r_valid_i;
    logic          r_ready_i;
    logic          r_last_i;
    logic [1:0]    r_resp_i;
    logic          busy_o;
    logic          err_o;
    logic [CW-1:0] outstanding_o;

    idma_axi_read_issue_tracker #(
        .NumOutstanding(N),
        .ar_chan_t     (ar_t),
        .r_dp_req_t    (dp_t)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_ar_i     (req_ar_i),
        .req_dp_i     (req_dp_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .ar_o         (ar_o),
        .ar_valid_o   (ar_valid_o),
        .ar_ready_i   (ar_ready_i),
        .dp_o         (dp_o),
        .dp_valid_o   (dp_valid_o),
        .dp_ready_i   (dp_ready_i),
        .r_valid_i    (r_valid_i),
        .r_ready_i    (r_ready_i),
        .r_last_i     (r_last_i),
        .r_resp_i     (r_resp_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .outstanding_o(outstanding_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int total;
    int bad;

    typedef struct {
        bit          rq;
        logic [31:0] addr;
        bit          ardy;
        bit          drdy;
        bit          rv;
        bit          rl;
        logic [1:0]  rsp;
        bit          e_rdy;
        bit          e_arv;
        bit          e_dpv;
        int          e_out;
        bit          e_busy;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    // scoreboard state for the random phase
    ar_t         exp_ar_q[$];
    logic [15:0] exp_q[$];
    int          m_out;
    bit          m_err;

    // ---------------- driver tasks ----------------
    function automatic dp_t dp_of(input logic [31:0] a);
        return a[15:0] ^ 16'h5a5a;
    endfunction

    function automatic ar_t ar_of(input logic [31:0] a);
        ar_t r;
        r.addr = a;
        r.len  = 8'd3;
        return r;
    endfunction

    function automatic vec_t mk(input bit rq, input logic [31:0] addr, input bit ardy,
                                input bit drdy, input bit rv, input bit rl, input logic [1:0] rsp,
                                input bit e_rdy, input bit e_arv, input bit e_dpv, input int e_out,
                                input bit e_busy, input bit e_err);
        vec_t v;
        v.rq = rq; v.addr = addr; v.ardy = ardy; v.drdy = drdy;
        v.rv = rv; v.rl = rl; v.rsp = rsp;
        v.e_rdy = e_rdy; v.e_arv = e_arv; v.e_dpv = e_dpv;
        v.e_out = e_out; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input bit rq, input logic [31:0] a, input bit ardy, input bit drdy,
                         input bit rv, input bit rl, input logic [1:0] rsp);
        req_valid_i = rq;
        req_ar_i    = ar_of(a);
        req_dp_i    = dp_of(a);
        ar_ready_i  = ardy;
        dp_ready_i  = drdy;
        r_valid_i   = rv;
        r_ready_i   = rv;
        r_last_i    = rl;
        r_resp_i    = rsp;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, 1, 1, 1, 2'b00);
            tick();
        end
        drive(0, 0, 1, 1, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("drain_out", outstanding_o, 0);
        chk("drain_busy", busy_o, 0);
        tick();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive(0, 0, 1, 1, 0, 0, 2'b00);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ar_valid", ar_valid_o, 0);
        chk("rst_ar", ar_o, 0);
        chk("rst_dp_valid", dp_valid_o, 0);
        chk("rst_dp", dp_o, 0);
        chk("rst_out", outstanding_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        do_reset();

        // single request, five back-to-back with throttling, error pulse
        tbl.push_back(mk(1, 'h100, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 1, 2'b00, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h200, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h240, 1, 1, 0, 0, 2'b00, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 'h280, 1, 1, 0, 0, 2'b00, 1, 1, 1, 2, 1, 0));
        tbl.push_back(mk(1, 'h2c0, 1, 1, 0, 0, 2'b00, 1, 1, 1, 3, 1, 0));
        tbl.push_back(mk(1, 'h300, 1, 1, 0, 0, 2'b00, 0, 1, 1, 4, 1, 0));
        tbl.push_back(mk(1, 'h300, 1, 1, 1, 1, 2'b00, 0, 0, 0, 4, 1, 0));
        tbl.push_back(mk(1, 'h300, 1, 1, 0, 0, 2'b00, 1, 0, 0, 3, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 0, 1, 1, 4, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 1, 2'b00, 0, 0, 0, 4, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 1, 2'b00, 1, 0, 0, 3, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 1, 2'b00, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 1, 2'b00, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 1, 0, 2'b01, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rq, tbl[i].addr, tbl[i].ardy, tbl[i].drdy,
                  tbl[i].rv, tbl[i].rl, tbl[i].rsp);
            @(negedge clk_i);
            chk($sformatf("vec%0d_ready", i), req_ready_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d_ar_valid", i), ar_valid_o, tbl[i].e_arv);
            chk($sformatf("vec%0d_dp_valid", i), dp_valid_o, tbl[i].e_dpv);
            chk($sformatf("vec%0d_out", i), outstanding_o, tbl[i].e_out);
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("vec%0d_err", i), err_o, tbl[i].e_err);
            if (i == 1) chk("vec1_ar_addr", ar_o, ar_of('h100));
            tick();
        end

        // AR stall: held payload, no second accept, reload on handshake edge
        drive(1, 'hA00, 0, 1, 0, 0, 2'b00);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 'hB00, 0, 1, 0, 0, 2'b00);
            @(negedge clk_i);
            chk("stall_ar_valid", ar_valid_o, 1);
            chk("stall_ar_hold", ar_o, ar_of('hA00));
            chk("stall_ready", req_ready_o, 0);
            chk("stall_out", outstanding_o, 1);
            tick();
        end
        drive(1, 'hB00, 1, 1, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("stall_release_ready", req_ready_o, 1);
        tick();
        drive(0, 0, 1, 1, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("stall_new_ar_valid", ar_valid_o, 1);
        chk("stall_new_ar", ar_o, ar_of('hB00));
        chk("stall_out2", outstanding_o, 2);
        tick();
        drain(2);

        // accept and completion on the same edge, FIFO holding three in order
        drive(1, 'hC10, 1, 0, 0, 0, 2'b00);
        tick();
        drive(1, 'hC20, 1, 0, 0, 0, 2'b00);
        tick();
        drive(1, 'hC30, 1, 0, 1, 1, 2'b00);
        @(negedge clk_i);
        chk("same_edge_out_before", outstanding_o, 2);
        chk("same_edge_ready", req_ready_o, 1);
        tick();
        drive(0, 0, 1, 1, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("same_edge_out_after", outstanding_o, 2);
        chk("fifo_e0", dp_o, dp_of('hC10));
        tick();
        @(negedge clk_i);
        chk("fifo_e1", dp_o, dp_of('hC20));
        tick();
        @(negedge clk_i);
        chk("fifo_e2", dp_o, dp_of('hC30));
        tick();
        @(negedge clk_i);
        chk("fifo_empty_after3", dp_valid_o, 0);
        tick();
        drain(2);

        // reset in the middle of activity
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hD00 + 32'(k), 1, 0, 0, 0, 2'b00);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("pre_rst_ar_valid", ar_valid_o, 1);
        chk("pre_rst_out", outstanding_o, 3);
        chk("pre_rst_dp_valid", dp_valid_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ar_valid", ar_valid_o, 0);
        chk("mid_rst_dp_valid", dp_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_out", outstanding_o, 0);
        tick();
        rst_ni = 1'b1;
        drive(0, 0, 1, 1, 0, 0, 2'b00);
        @(negedge clk_i);
        chk("post_rst_ready", req_ready_o, 1);
        chk("post_rst_dp_valid", dp_valid_o, 0);
        tick();

        // randomized traffic against the queue model
        do_reset();
        m_out = 0;
        m_err = 0;
        exp_ar_q.delete();
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            bit exp_rdy;
            bit acc;
            drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 5, 0, 0, 2'($urandom_range(0, 3)));
            req_ar_i.len = 8'($urandom);
            req_dp_i     = 16'($urandom);
            r_valid_i    = $urandom_range(0, 1) == 1;
            r_ready_i    = $urandom_range(0, 9) < 7;
            r_last_i     = (m_out > 0) && ($urandom_range(0, 9) < 5);
            @(negedge clk_i);
            exp_rdy = (exp_ar_q.size() == 0 || ar_ready_i) && (exp_q.size() < N) && (m_out < N);
            chk("rnd_ready", req_ready_o, exp_rdy);
            chk("rnd_ar_valid", ar_valid_o, exp_ar_q.size() != 0);
            if (exp_ar_q.size() != 0) chk("rnd_ar", ar_o, exp_ar_q[0]);
            chk("rnd_dp_valid", dp_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("rnd_dp", dp_o, exp_q[0]);
            chk("rnd_out", outstanding_o, m_out);
            chk("rnd_busy", busy_o, (exp_ar_q.size() != 0) || (m_out != 0));
            chk("rnd_err", err_o, m_err);
            acc = req_valid_i && exp_rdy;
            if (exp_ar_q.size() != 0 && ar_ready_i) void'(exp_ar_q.pop_front());
            if (acc) exp_ar_q.push_back(req_ar_i);
            if (exp_q.size() != 0 && dp_ready_i) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(req_dp_i);
            if (acc) m_out++;
            if (r_valid_i && r_ready_i && r_last_i) m_out--;
            m_err = r_valid_i && r_ready_i && r_resp_i[1];
            tick();
        end

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
